burst_bus_mem: RTL and testbench
================================

# burst_bus_mem

Multi-channel burst interconnect with an on-block register memory. It is the parametrised successor of the single master/slave FSM pair. NCH independent requesters issue incrementing read or write bursts, and a round-robin arbiter grants one burst at a time. A burst FSM moves the data beats to or from a DEPTH-word memory. The block sits between the request FSMs and storage, under the top-level `io_start` enable.

## Interface
Parameters:
- NCH, 2: number of requester channels (≥1)
- DW, 32: data width
- AW, 4: address width; DEPTH = 2^AW words
- LW, 4: burst length field width

Ports (vectors are flattened, channel c in slice c):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- io_start  in  1  grant enable; when 0 no new burst is granted
- io_req_valid  in  NCH  burst request per channel
- io_req_wr  in  NCH  1 = write burst, 0 = read burst
- io_req_address  in  NCH*AW  start word address
- io_req_length  in  NCH*LW  beat count; 0 is treated as 1
- io_req_ready  out  NCH  one-cycle grant/accept pulse, one-hot
- io_wdata  in  NCH*DW  write beat data
- io_wvalid  in  NCH  write beat valid
- io_wready  out  NCH  write beat ready (granted channel only)
- io_rdata  out  DW  read beat data
- io_rvalid  out  NCH  read beat valid, one-hot channel tag
- io_done  out  NCH  one-cycle burst-complete pulse
- io_err  out  NCH  one-cycle error pulse, coincident with io_done
- io_busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: if io_start and any io_req_valid, the round-robin winner g is granted. io_req_ready[g]=1 that cycle.
- On grant, address, beat count and direction are latched. Next state is WRITE or READ.
- WRITE:
  - io_wready[g]=1.
  - A beat occurs when io_wvalid[g]=1; mem[addr] is written with io_wdata[g], addr increments and count decrements.
  - Cycles without io_wvalid stall with no timeout.
  - After the last beat the FSM goes to DONE.
- READ:
  - io_rvalid[g]=1 every cycle with io_rdata = mem[addr] (combinational).
  - addr increments each cycle. There is no backpressure.
  - After the last beat the FSM goes to DONE.
- DONE: io_done[g]=1 for one cycle. The round-robin pointer moves to g+1 mod NCH. Next state is IDLE.
- Arbitration: search starts at the pointer. After reset the pointer is 0, so channel 0 wins first. Requests are sampled only in IDLE.
- Address arithmetic is AW bits, modulo DEPTH. The count register is LW+1 bits, so length 2^LW-1 is supported.
- Deasserting io_start mid-burst does not abort the burst. It only blocks the next grant.
- Requests that change while not granted are ignored. A requester holds valid until it sees ready.

## Timing
- Reset values: state IDLE, pointer 0, every memory word 0.
- All outputs are 0 during reset. io_rdata is 0 outside READ.
- Write burst of L beats with io_wvalid always high: grant at cycle T, beats T+1..T+L, io_done at T+L+1, IDLE at T+L+2.
- Read burst of L beats: grant at T, rvalid T+1..T+L, io_done at T+L+1.
- Minimum spacing between two grants is L+2 cycles.
- Reset asserted mid-burst: immediate return to IDLE. A partial write is kept except for memory, which clears to 0.

## Configuration
- BURSTBUS_WRAP_ERR_EN defined:
  - A request with address + length > DEPTH is accepted (io_req_ready pulses).
  - It performs no memory access and goes straight to DONE with io_err[g]=1 and io_done[g]=1.
  - For a write, io_wready stays 0.
- BURSTBUS_WRAP_ERR_EN undefined: bursts wrap modulo DEPTH and io_err is tied to 0.

## Structure
- Package burst_bus_pkg holds:
  - the state enum (IDLE/WRITE/READ/DONE)
  - default parameter constants
  - a channel-index width function (clog2 NCH, minimum 1)
- Sub-module rr_arbiter(NCH): inputs are the request vector, pointer and enable; output is the one-hot grant. It is purely combinational.
- The pointer register lives in the parent.

## Test plan
- Reset then write ch0 addr 7 len 4, data A,B,C,D → io_wready for 4 cycles, io_done[0] at grant+5. Then read ch0 addr 7 len 4 → io_rdata A,B,C,D over 4 cycles.
- Ch0 and ch1 request in the same cycle, both len 1 → ch0 granted first, ch1 granted 3 cycles later. Repeat → ch1 is not starved under continuous ch0 requests.
- Write len 3 with io_wvalid low for 2 cycles mid-burst → burst stalls, exactly 3 words written, io_done 2 cycles later than nominal.
- Write addr 14 len 4, DEPTH 16:
  - Without the macro: words 14,15,0,1 are written and io_err stays 0.
  - With the macro: io_err[ch]=io_done[ch]=1 one cycle after grant and memory is unchanged.
- io_start=0 with pending requests → no io_req_ready. io_start dropped mid-burst → current burst completes, next request is held.
- reset pulled low during a read burst → io_rvalid and io_busy go 0 immediately, and a read of 0 after release returns 0.

Source files
------------

// File: rtl/burst_bus_pkg.sv
// Shared types and constants for the burst_bus_mem interconnect.
// Holds the burst FSM state encoding, the default parameter values and the
// helper that sizes channel-index registers.
package burst_bus_pkg;

  localparam int DEF_NCH = 2;
  localparam int DEF_DW  = 32;
  localparam int DEF_AW  = 4;
  localparam int DEF_LW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a channel index; a single-channel build still gets one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/burst_bus_mem_arb.sv
// rr_arbiter: combinational round-robin grant for NCH requesters.
// Channels at or above the pointer are preferred; if none of them request,
// the search wraps to the lowest requesting channel. The grant is one-hot,
// or all zero when disabled or when nobody requests.
module rr_arbiter
  import burst_bus_pkg::*;
#(
  parameter  int NCH = DEF_NCH,
  localparam int CW  = ch_w(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CW-1:0]  i_ptr,
  input  logic           i_en,
  output logic [NCH-1:0] o_grant
);

  logic [NCH-1:0] w_hi;
  logic [NCH-1:0] w_hi_first;
  logic [NCH-1:0] w_all_first;

  // Requests at or above the pointer, then the lowest set bit of each set.
  assign w_hi        = i_req & ({NCH{1'b1}} << i_ptr);
  assign w_hi_first  = w_hi & (~w_hi + 1'b1);
  assign w_all_first = i_req & (~i_req + 1'b1);

  // Wrap to the lowest requester only when nothing sits at or above the pointer.
  assign o_grant = !i_en ? '0 : ((|w_hi) ? w_hi_first : w_all_first);

endmodule

// File: rtl/burst_bus_mem.sv
// burst_bus_mem: NCH-channel burst interconnect in front of a DEPTH-word
// register memory. A round-robin arbiter grants one incrementing read or
// write burst at a time; the burst FSM moves one beat per cycle (writes
// stall while the granted channel holds wvalid low).
// Optional feature: define BURSTBUS_WRAP_ERR_EN to reject bursts that would
// run past the top of memory (accepted, no access, io_err with io_done).
// Without it, bursts wrap modulo DEPTH and io_err is constant 0.
module burst_bus_mem
  import burst_bus_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int LW  = DEF_LW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [NCH-1:0]    io_req_valid,
  input  logic [NCH-1:0]    io_req_wr,
  input  logic [NCH*AW-1:0] io_req_address,
  input  logic [NCH*LW-1:0] io_req_length,
  output logic [NCH-1:0]    io_req_ready,
  input  logic [NCH*DW-1:0] io_wdata,
  input  logic [NCH-1:0]    io_wvalid,
  output logic [NCH-1:0]    io_wready,
  output logic [DW-1:0]     io_rdata,
  output logic [NCH-1:0]    io_rvalid,
  output logic [NCH-1:0]    io_done,
  output logic [NCH-1:0]    io_err,
  output logic              io_busy
);

  localparam int CW    = ch_w(NCH);
  localparam int DEPTH = 1 << AW;

  state_t          r_state;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_ch;
  logic [AW-1:0]   r_addr;
  logic [LW:0]     r_cnt;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [NCH-1:0]  w_grant;
  logic            w_arb_en;
  logic [CW-1:0]   w_gidx;
  logic            w_gwr;
  logic [AW-1:0]   w_req_addr;
  logic [LW-1:0]   w_req_len;
  logic [LW:0]     w_len_eff;
  logic            w_wrap_err;
  logic [NCH-1:0]  w_ch_oh;
  logic [DW-1:0]   w_wdata;
  logic            w_wvalid;
  logic            w_wbeat;
  logic            w_last;

  // Grants only happen in IDLE, with io_start high, and never under reset.
  assign w_arb_en = (r_state == IDLE) && io_start && reset;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_req   (io_req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  // Pick the winner's index and request fields out of the flattened vectors.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    w_gidx     = '0;
    w_gwr      = 1'b0;
    w_req_addr = '0;
    w_req_len  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_grant[c]) begin
        w_gidx     = CW'(c);
        w_gwr      = io_req_wr[c];
        w_req_addr = io_req_address[c*AW +: AW];
        w_req_len  = io_req_length[c*LW +: LW];
      end
    end
  end

  // A zero-length request still moves one beat.
  assign w_len_eff = (w_req_len == '0) ? (LW+1)'(1) : {1'b0, w_req_len};

  // Decode the latched channel and select its write-side inputs.
  always_comb begin
    w_ch_oh  = '0;
    w_wdata  = '0;
    w_wvalid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (r_ch == CW'(c)) begin
        w_ch_oh[c] = 1'b1;
        w_wdata    = io_wdata[c*DW +: DW];
        w_wvalid   = io_wvalid[c];
      end
    end
  end

  assign w_wbeat = (r_state == WRITE) && w_wvalid;
  assign w_last  = (r_cnt == (LW+1)'(1));

`ifdef BURSTBUS_WRAP_ERR_EN
  logic r_err;

  // Out-of-range when the burst would touch a word at or beyond DEPTH.
  assign w_wrap_err = (int'(w_req_addr) + int'(w_len_eff)) > DEPTH;

  // Remember whether the granted burst was rejected, for the DONE pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (|w_grant) begin
      r_err <= w_wrap_err;
    end
  end

  assign io_err = w_ch_oh & {NCH{(r_state == DONE) && r_err}};
`else
  assign w_wrap_err = 1'b0;
  assign io_err     = '0;
`endif

  // Burst FSM: grant and latch in IDLE, one beat per cycle, pointer update in DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // here samples the values from before this edge, matching the hardware.
      unique case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_ch   <= w_gidx;
            r_addr <= w_req_addr;
            r_cnt  <= w_len_eff;
            if (w_wrap_err) begin
              r_state <= DONE;
            end else begin
              r_state <= w_gwr ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (w_wvalid) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        READ: begin
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= (r_ch == CW'(NCH - 1)) ? '0 : r_ch + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage: one write port driven by accepted write beats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the memory is cleared on reset because the block promises all
      // words read back as 0 afterwards; this keeps it as flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wbeat) begin
      r_mem[r_addr] <= w_wdata;
    end
  end

  // Channel-tagged handshakes decoded from the registered state and channel.
  assign io_req_ready = w_grant;
  assign io_wready    = w_ch_oh & {NCH{r_state == WRITE}};
  assign io_rvalid    = w_ch_oh & {NCH{r_state == READ}};
  assign io_done      = w_ch_oh & {NCH{r_state == DONE}};
  assign io_rdata     = (r_state == READ) ? r_mem[r_addr] : '0;
  assign io_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_burst_bus_mem.sv
// Directed bench for burst_bus_mem (NCH=2, DW=32, AW=4, LW=4).
// Inputs change on the falling clock edge; outputs are sampled 1 time unit
// later, so each check sees the state left by the preceding rising edge.
// Honours BURSTBUS_WRAP_ERR_EN for the out-of-range burst expectations.
module tb_burst_bus_mem;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int LW  = 4;

  logic              clock;
  logic              reset;
  logic              io_start;
  logic [NCH-1:0]    io_req_valid;
  logic [NCH-1:0]    io_req_wr;
  logic [NCH*AW-1:0] io_req_address;
  logic [NCH*LW-1:0] io_req_length;
  logic [NCH-1:0]    io_req_ready;
  logic [NCH*DW-1:0] io_wdata;
  logic [NCH-1:0]    io_wvalid;
  logic [NCH-1:0]    io_wready;
  logic [DW-1:0]     io_rdata;
  logic [NCH-1:0]    io_rvalid;
  logic [NCH-1:0]    io_done;
  logic [NCH-1:0]    io_err;
  logic              io_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] dat [0:10];

  burst_bus_mem #(.NCH(NCH), .DW(DW), .AW(AW), .LW(LW)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_start       (io_start),
    .io_req_valid   (io_req_valid),
    .io_req_wr      (io_req_wr),
    .io_req_address (io_req_address),
    .io_req_length  (io_req_length),
    .io_req_ready   (io_req_ready),
    .io_wdata       (io_wdata),
    .io_wvalid      (io_wvalid),
    .io_wready      (io_wready),
    .io_rdata       (io_rdata),
    .io_rvalid      (io_rvalid),
    .io_done        (io_done),
    .io_err         (io_err),
    .io_busy        (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic req(input int ch, input logic wr, input int a, input int l);
    io_req_valid[ch]              = 1'b1;
    io_req_wr[ch]                 = wr;
    io_req_address[ch*AW +: AW]   = AW'(a);
    io_req_length[ch*LW +: LW]    = LW'(l);
  endtask

  task automatic wbeat(input int ch, input logic v, input logic [31:0] d);
    io_wvalid          = '0;
    io_wvalid[ch]      = v;
    io_wdata[ch*DW +: DW] = d;
  endtask

  initial begin
    dat[0] = 32'hA000_000A; dat[1] = 32'hB000_000B;
    dat[2] = 32'hC000_000C; dat[3] = 32'hD000_000D;
    dat[4] = 32'hE000_000E; dat[5] = 32'hF000_000F;
    dat[6] = 32'h1234_5678; dat[7] = 32'h2222_1111;
    dat[8] = 32'h3333_4444; dat[9] = 32'h5555_6666;
    dat[10] = 32'h7777_8888;

    reset = 1'b0; io_start = 1'b1; io_req_valid = 2'b11; io_req_wr = '0;
    io_req_address = '0; io_req_length = '0; io_wdata = '0; io_wvalid = '0;

    // Reset: every output quiet even with requests pending.
    tick(); #1;
    check("rst_ready", io_req_ready, 0);
    check("rst_busy",  io_busy, 0);
    check("rst_rvalid", io_rvalid, 0);
    check("rst_wready", io_wready, 0);
    check("rst_done",  io_done, 0);
    check("rst_err",   io_err, 0);
    check("rst_rdata", io_rdata, 0);
    io_req_valid = '0;
    tick(); reset = 1'b1;

    // Arbitration: simultaneous len-1 reads, ch0 keeps requesting.
    tick(); req(0, 0, 0, 1); req(1, 0, 0, 1); #1;
    check("arb_first_ch0", io_req_ready, 2'b01);
    tick(); #1;
    check("arb_hold_ready", io_req_ready, 2'b00);
    check("arb_rvalid0", io_rvalid, 2'b01);
    check("arb_busy", io_busy, 1);
    tick(); #1;
    check("arb_done0", io_done, 2'b01);
    tick(); #1;
    check("arb_ch1_plus3", io_req_ready, 2'b10);
    tick(); io_req_valid[1] = 1'b0; #1;
    check("arb_rvalid1", io_rvalid, 2'b10);
    tick(); #1;
    check("arb_done1", io_done, 2'b10);
    tick(); #1;
    check("arb_back_ch0", io_req_ready, 2'b01);
    tick(); io_req_valid = '0; #1;
    check("arb_rvalid0b", io_rvalid, 2'b01);
    tick(); #1;
    check("arb_done0b", io_done, 2'b01);

    // Write ch0 addr 7 len 4, wvalid always high.
    tick(); req(0, 1, 7, 4); #1;
    check("wr_grant", io_req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick(); io_req_valid = '0; wbeat(0, 1'b1, dat[i]); #1;
      check("wr_wready", io_wready, 2'b01);
    end
    tick(); wbeat(0, 1'b0, 0); #1;
    check("wr_done", io_done, 2'b01);
    check("wr_err", io_err, 0);
    check("wr_wready_off", io_wready, 0);
    tick(); #1;
    check("wr_idle", io_busy, 0);

    // Read back ch0 addr 7 len 4.
    tick(); req(0, 0, 7, 4); #1;
    check("rd_grant", io_req_ready, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick(); io_req_valid = '0; #1;
      check("rd_rvalid", io_rvalid, 2'b01);
      check("rd_data", io_rdata, dat[i]);
    end
    tick(); #1;
    check("rd_done", io_done, 2'b01);
    check("rd_rdata_zero", io_rdata, 0);

    // Stalled write: ch1 addr 2 len 3, wvalid low for two cycles.
    tick(); req(1, 1, 2, 3); #1;
    check("st_grant", io_req_ready, 2'b10);
    tick(); io_req_valid = '0; wbeat(1, 1'b1, dat[4]); #1;
    check("st_wready", io_wready, 2'b10);
    tick(); wbeat(1, 1'b0, 0); #1;
    check("st_wready_stall", io_wready, 2'b10);
    tick(); #1;
    check("st_no_done_nominal", io_done, 0);
    tick(); wbeat(1, 1'b1, dat[5]); #1;
    tick(); wbeat(1, 1'b1, dat[6]); #1;
    check("st_no_done_early", io_done, 0);
    tick(); wbeat(1, 1'b0, 0); #1;
    check("st_done_late", io_done, 2'b10);

    // Read ch1 addr 1 len 5: only words 2..4 were written.
    tick(); req(1, 0, 1, 5); #1;
    check("st_rd_grant", io_req_ready, 2'b10);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e;
      e = (i == 0 || i == 4) ? 32'h0 : dat[3 + i];
      tick(); io_req_valid = '0; #1;
      check("st_rd_data", io_rdata, e);
    end
    tick(); #1;
    check("st_rd_done", io_done, 2'b10);

    // Length 0 behaves as one beat.
    tick(); req(0, 0, 2, 0); #1;
    check("l0_grant", io_req_ready, 2'b01);
    tick(); io_req_valid = '0; #1;
    check("l0_data", io_rdata, dat[4]);
    tick(); #1;
    check("l0_done", io_done, 2'b01);

    // Write past the top: addr 14 len 4.
    tick(); req(0, 1, 14, 4); #1;
    check("wrap_grant", io_req_ready, 2'b01);
`ifdef BURSTBUS_WRAP_ERR_EN
    tick(); io_req_valid = '0; wbeat(0, 1'b1, dat[7]); #1;
    check("wrap_wready_off", io_wready, 0);
    check("wrap_done", io_done, 2'b01);
    check("wrap_err", io_err, 2'b01);
    tick(); wbeat(0, 1'b0, 0); #1;
    check("wrap_idle", io_busy, 0);
    check("wrap_err_off", io_err, 0);
`else
    for (int i = 0; i < 4; i++) begin
      tick(); io_req_valid = '0; wbeat(0, 1'b1, dat[7 + i]); #1;
      check("wrap_wready", io_wready, 2'b01);
      check("wrap_err_low", io_err, 0);
    end
    tick(); wbeat(0, 1'b0, 0); #1;
    check("wrap_done", io_done, 2'b01);
    check("wrap_err", io_err, 0);
`endif
    for (int p = 0; p < 2; p++) begin
      tick(); req(0, 0, (p == 0) ? 14 : 0, 2); #1;
      check("wrap_rd_grant", io_req_ready, 2'b01);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] e;
`ifdef BURSTBUS_WRAP_ERR_EN
        e = 32'h0;
`else
        e = dat[7 + 2*p + i];
`endif
        tick(); io_req_valid = '0; #1;
        check("wrap_rd_data", io_rdata, e);
      end
      tick(); #1;
      check("wrap_rd_done", io_done, 2'b01);
    end

    // io_start gating: pending request waits; dropping mid-burst completes it.
    io_start = 1'b0;
    tick(); req(1, 0, 3, 2); #1;
    check("gate_no_ready", io_req_ready, 0);
    check("gate_idle", io_busy, 0);
    tick(); #1;
    check("gate_no_ready2", io_req_ready, 0);
    tick(); io_start = 1'b1; #1;
    check("gate_grant", io_req_ready, 2'b10);
    tick(); io_start = 1'b0; io_req_valid = '0; req(0, 0, 4, 1); #1;
    check("gate_rd0", io_rdata, dat[5]);
    check("gate_rv0", io_rvalid, 2'b10);
    tick(); #1;
    check("gate_rd1", io_rdata, dat[6]);
    tick(); #1;
    check("gate_done", io_done, 2'b10);
    tick(); #1;
    check("gate_held", io_req_ready, 0);
    check("gate_held_idle", io_busy, 0);
    tick(); io_start = 1'b1; #1;
    check("gate_release", io_req_ready, 2'b01);
    tick(); io_req_valid = '0; #1;
    check("gate_rd2", io_rdata, dat[6]);
    tick(); #1;
    check("gate_done2", io_done, 2'b01);

    // Reset in the middle of a read burst.
    tick(); req(0, 0, 2, 4); #1;
    check("mr_grant", io_req_ready, 2'b01);
    tick(); io_req_valid = '0; #1;
    check("mr_data", io_rdata, dat[4]);
    tick(); reset = 1'b0; #1;
    check("mr_rvalid", io_rvalid, 0);
    check("mr_busy", io_busy, 0);
    check("mr_rdata", io_rdata, 0);
    tick(); reset = 1'b1;
    tick(); req(0, 0, 2, 1); #1;
    check("mr_grant2", io_req_ready, 2'b01);
    tick(); io_req_valid = '0; #1;
    check("mr_rvalid2", io_rvalid, 2'b01);
    check("mr_cleared", io_rdata, 0);
    tick(); #1;
    check("mr_done2", io_done, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
